writeback_scheduler: RTL
========================

WRITEBACK_SCHEDULER -- requirements
Module: writeback_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: issue_valid_i  in  1  instruction offered for issue this cycle.
REQ-004 SHALL have ports: single_cycle_i  in  1  latency class from decoder, result after 1 cycle.
REQ-005 SHALL have ports: multi_cycle_i  in  1  latency class from decoder, result after 4 cycles.
REQ-006 SHALL have ports: dest_reg_i  in  5  destination register of offered instruction.
REQ-007 SHALL have ports: src_a_i, src_b_i  in  5 each  source registers; src_valid_i  in  2  per-source use flags ([0]=a, [1]=b).
REQ-008 SHALL have ports: flush_i  in  1  cancel all in-flight reservations.
REQ-009 SHALL have ports: issue_ready_o  out  1  combinational, offered instruction may issue.
REQ-010 SHALL have ports: wb_valid_o  out  1  registered, a result writes back this cycle; wb_reg_o  out  5  its register.
REQ-011 SHALL have ports: idle_o  out  1  no reservations and no pending registers.

Function
REQ-012 SHALL accept an instruction iff issue_valid_i && issue_ready_o in the same cycle.
REQ-013 SHALL treat single_cycle_i=0 and multi_cycle_i=0 (NOP) as no reservation; issue_ready_o=1 for NOP.
REQ-014 SHALL treat single_cycle_i=1 and multi_cycle_i=1 together as multi-cycle.
REQ-015 SHALL keep a 4-entry slot shift register s0..s3 (valid + 5-bit reg); wb_valid_o/wb_reg_o = s0.
REQ-016 SHALL each cycle perform s0<=s1, s1<=s2, s2<=s3, s3<=empty, then apply accepted reservations.
REQ-017 SHALL load an accepted single-cycle instruction into s0: wb_valid_o asserted exactly 1 cycle after issue.
REQ-018 SHALL load an accepted multi-cycle instruction into s3: wb_valid_o asserted exactly 4 cycles after issue.
REQ-019 SHALL deassert issue_ready_o for a single-cycle instruction when s1 is valid (port collision).
REQ-020 SHALL keep a 32-bit pending vector; an accepted multi-cycle instruction sets pending[dest_reg_i].
REQ-021 SHALL clear pending[wb_reg_o] in the cycle wb_valid_o=1 (effective next cycle).
REQ-022 SHALL deassert issue_ready_o when a used source is pending and not equal to wb_reg_o with wb_valid_o=1 (RAW; same-cycle writeback counts as available).
REQ-023 SHALL deassert issue_ready_o for any single- or multi-cycle instruction whose dest_reg_i is pending and not being written back this cycle (WAW).
REQ-024 SHALL make issue_ready_o depend only on current state and current inputs, never on issue_valid_i.
REQ-025 SHALL on flush_i=1 clear s0..s3 and pending next cycle, ignore any same-cycle issue, and force issue_ready_o=0 that cycle.
REQ-026 SHALL never drive wb_valid_o=1 in the cycle after flush_i=1.
REQ-027 SHALL assert idle_o when all slot valids and all pending bits are 0.
REQ-028 SHALL not allocate any reservation when issue_valid_i=0, regardless of class inputs.

Reset
REQ-029 SHALL on reset_n=0 asynchronously clear all slots and pending bits: wb_valid_o=0, wb_reg_o=0, idle_o=1.
REQ-030 SHALL discard in-flight multi-cycle results when reset asserts mid-operation; no writeback after reset release until a new issue.
REQ-031 SHALL resume normal issue on the first rising clk edge after reset_n deasserts.

Verification
REQ-032 SHALL cover: single-cycle issue dest=5 at cycle 0 -> wb_valid_o=1, wb_reg_o=5 at cycle 1 only.
REQ-033 SHALL cover: multi-cycle dest=7 at cycle 0, single-cycle offered at cycle 3 -> issue_ready_o=0 at cycle 3, wb_reg_o=7 at cycle 4, single accepted at cycle 4 writes back at cycle 5.
REQ-034 SHALL cover: multi-cycle dest=9 at cycle 0, instruction with src_a=9 offered cycles 1-4 -> ready=0 cycles 1-3, ready=1 at cycle 4.
REQ-035 SHALL cover: multi-cycle dest=3 at cycle 0, single-cycle dest=3 at cycle 1 -> stalled until cycle 4 (WAW).
REQ-036 SHALL cover: two multi-cycle issues (dest 1, 2) at cycles 0 and 1, flush_i at cycle 2 -> wb_valid_o=0 cycles 3-6, idle_o=1 at cycle 3.
REQ-037 SHALL cover: reset_n pulled low at cycle 2 after multi issue at cycle 0 -> wb_valid_o stays 0 through cycle 6, idle_o=1.

Source files
------------

// File: rtl/writeback_scheduler.sv
// Writeback port scheduler: reserves the shared writeback slot for 1- and 4-cycle ops
// and tracks registers with outstanding multi-cycle results for RAW/WAW interlocks.

module wb_slot #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load,
    input  logic [REG_W-1:0] load_rd,
    input  logic             shift_vld,
    input  logic [REG_W-1:0] shift_rd,
    output logic             vld,
    output logic [REG_W-1:0] rd
);
    // A load always lands in a slot the shift has just vacated or overwritten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= 1'b0;
            rd  <= '0;
        end else if (flush) begin
            vld <= 1'b0;
            rd  <= '0;
        end else if (load) begin
            vld <= 1'b1;
            rd  <= load_rd;
        end else begin
            vld <= shift_vld;
            rd  <= shift_rd;
        end
    end
endmodule

module writeback_scheduler #(
    parameter int REG_W     = 5,
    parameter int MULTI_LAT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             issue_valid_i,
    input  logic             single_cycle_i,
    input  logic             multi_cycle_i,
    input  logic [REG_W-1:0] dest_reg_i,
    input  logic [REG_W-1:0] src_a_i,
    input  logic [REG_W-1:0] src_b_i,
    input  logic [1:0]       src_valid_i,
    input  logic             flush_i,
    output logic             issue_ready_o,
    output logic             wb_valid_o,
    output logic [REG_W-1:0] wb_reg_o,
    output logic             idle_o
);
    localparam int NUM_REGS  = 1 << REG_W;
    localparam int NUM_SLOTS = MULTI_LAT;

    logic [NUM_SLOTS-1:0]            slot_vld;
    logic [NUM_SLOTS-1:0][REG_W-1:0] slot_rd;
    logic [NUM_REGS-1:0]             pending_q, pending_d;
    logic [NUM_REGS-1:0]             wb_onehot, set_onehot, avail;

    logic is_multi, is_single, is_nop;
    logic src_a_ok, src_b_ok, dest_ok;
    logic acc, acc_single, acc_multi;

    // Both class bits set is treated as multi-cycle.
    assign is_multi  = multi_cycle_i;
    assign is_single = single_cycle_i & ~multi_cycle_i;
    assign is_nop    = ~single_cycle_i & ~multi_cycle_i;

    always_comb begin
        wb_onehot = '0;
        if (slot_vld[0]) wb_onehot[slot_rd[0]] = 1'b1;
    end

    // A register being written back this cycle counts as available.
    assign avail    = ~pending_q | wb_onehot;
    assign src_a_ok = ~src_valid_i[0] | avail[src_a_i];
    assign src_b_ok = ~src_valid_i[1] | avail[src_b_i];
    assign dest_ok  = avail[dest_reg_i];

    always_comb begin
        issue_ready_o = 1'b0;
        if (flush_i)
            issue_ready_o = 1'b0;
        else if (is_nop)
            issue_ready_o = 1'b1;
        else
            issue_ready_o = src_a_ok & src_b_ok & dest_ok & (is_multi | ~slot_vld[1]);
    end

    assign acc        = issue_valid_i & issue_ready_o & ~flush_i;
    assign acc_single = acc & is_single;
    assign acc_multi  = acc & is_multi;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic             sh_vld;
        logic [REG_W-1:0] sh_rd;
        logic             ld;
        if (i == NUM_SLOTS-1) begin : g_top
            assign sh_vld = 1'b0;
            assign sh_rd  = '0;
            assign ld     = acc_multi;
        end else if (i == 0) begin : g_bot
            assign sh_vld = slot_vld[i+1];
            assign sh_rd  = slot_rd[i+1];
            assign ld     = acc_single;
        end else begin : g_mid
            assign sh_vld = slot_vld[i+1];
            assign sh_rd  = slot_rd[i+1];
            assign ld     = 1'b0;
        end
        wb_slot #(.REG_W(REG_W)) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush_i),
            .load      (ld),
            .load_rd   (dest_reg_i),
            .shift_vld (sh_vld),
            .shift_rd  (sh_rd),
            .vld       (slot_vld[i]),
            .rd        (slot_rd[i])
        );
    end

    always_comb begin
        set_onehot = '0;
        if (acc_multi) set_onehot[dest_reg_i] = 1'b1;
    end

    // A new reservation on the register retiring this cycle must stay pending.
    always_comb begin
        pending_d = (pending_q & ~wb_onehot) | set_onehot;
        if (flush_i) pending_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending_q <= '0;
        else          pending_q <= pending_d;
    end

    assign wb_valid_o = slot_vld[0];
    assign wb_reg_o   = slot_rd[0];
    assign idle_o     = ~(|slot_vld) & ~(|pending_q);
endmodule
